// File: rtl/pushbutton_conditioner.sv
// rtl/pushbutton_conditioner.sv - per-channel synchronizer, debouncer and press/release/toggle generator
//
// Purpose:
//   Conditions asynchronous active-high push-button pins into glitch-free
//   signals. Each channel is synchronized, debounced by counting consecutive
//   samples that disagree with the stable level, and then produces a level,
//   one-cycle press/release pulses and a press-toggled latch.
//
// Parameters:
//   N_BUTTONS       - number of independent channels
//   SYNC_STAGES     - synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES - consecutive mismatching samples needed to accept a change (>= 1)
//
// Ports:
//   clk         - single rising-edge clock
//   rst_n       - asynchronous active-low reset
//   btn_raw     - raw pins, 1 = pressed, asynchronous to clk
//   btn_level   - debounced level (registered)
//   btn_press   - one-cycle pulse on the first cycle of a new high level
//   btn_release - one-cycle pulse on the first cycle of a new low level
//   btn_toggle  - inverts on every accepted press

module pushbutton_conditioner #(
  parameter int N_BUTTONS       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_toggle
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } db_state_t;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   stable_level;
    db_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   rls_q;
    logic                   toggle_q;

    // Shift register synchronizer; the last stage is the debouncer's sample.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
      end
    end

    assign sample       = sync_q[SYNC_STAGES-1];
    assign stable_level = (state_q == STABLE_HI) || (state_q == PEND_LO);

    // Debounce FSM. The counter holds the length of the current run of
    // samples disagreeing with the stable level; any agreeing sample aborts
    // the run, and the run's last permitted sample commits the new level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= STABLE_LO;
        cnt_q    <= '0;
        level_q  <= 1'b0;
        press_q  <= 1'b0;
        rls_q    <= 1'b0;
        toggle_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rls_q   <= 1'b0;
        if (sample == stable_level) begin
          cnt_q   <= '0;
          state_q <= stable_level ? STABLE_HI : STABLE_LO;
        end else if (cnt_q != CNT_MAX) begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= stable_level ? PEND_LO : PEND_HI;
        end else begin
          cnt_q   <= '0;
          level_q <= sample;
          state_q <= sample ? STABLE_HI : STABLE_LO;
          if (sample) begin
            press_q  <= 1'b1;
            toggle_q <= ~toggle_q;
          end else begin
            rls_q <= 1'b1;
          end
        end
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rls_q;
    assign btn_toggle[i]  = toggle_q;
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb/tb_pushbutton_conditioner.sv - self-checking bench for pushbutton_conditioner

module tb_pushbutton_conditioner;

  localparam int N = 2;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_toggle;

  pushbutton_conditioner #(
    .N_BUTTONS(N),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_toggle(btn_toggle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the synchronizer is a pure S-sample delay, and a level
  // change is accepted once the last D delayed samples since the previous
  // acceptance all differ from the current level.
  bit pipe[N][$];
  bit hist[N][$];
  bit m_level[N];
  bit m_press[N];
  bit m_rel[N];
  bit m_tog[N];

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) begin
      pipe[ch].delete();
      for (int k = 0; k < S; k++) pipe[ch].push_back(1'b0);
      hist[ch].delete();
      m_level[ch] = 1'b0;
      m_press[ch] = 1'b0;
      m_rel[ch]   = 1'b0;
      m_tog[ch]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit s;
    bit all_diff;
    int sz;
    if (!rst_n) return;
    for (int ch = 0; ch < N; ch++) begin
      s = pipe[ch].pop_front();
      pipe[ch].push_back(btn_raw[ch]);
      m_press[ch] = 1'b0;
      m_rel[ch]   = 1'b0;
      hist[ch].push_back(s);
      if (hist[ch].size() > D) void'(hist[ch].pop_front());
      sz = hist[ch].size();
      all_diff = (sz >= D);
      for (int k = 0; k < sz; k++)
        if (hist[ch][k] == m_level[ch]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[ch] = s;
        if (s) begin
          m_press[ch] = 1'b1;
          m_tog[ch]   = ~m_tog[ch];
        end else begin
          m_rel[ch] = 1'b1;
        end
        hist[ch].delete();
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] el, ep, er, et;
    for (int ch = 0; ch < N; ch++) begin
      el[ch] = m_level[ch];
      ep[ch] = m_press[ch];
      er[ch] = m_rel[ch];
      et[ch] = m_tog[ch];
    end
    check("level", 32'(btn_level), 32'(el));
    check("press", 32'(btn_press), 32'(ep));
    check("release", 32'(btn_release), 32'(er));
    check("toggle", 32'(btn_toggle), 32'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic assert_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
  endtask

  task automatic release_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic wait_pulse(input int ch, input bit rel, output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (rel ? btn_release[ch] : btn_press[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic fresh_reset();
    assert_reset();
    tick();
    release_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int lat;
  int cnt;
  int hold[N];
  logic [N-1:0] tog_seen;

  initial begin
    model_reset();
    btn_raw = 2'b11;
    #1;
    check_outputs();
    ticks(3);
    release_reset();
    wait_pulse(0, 1'b0, lat);
    check("rst_press_lat", lat, 6);
    check("rst_press_both", 32'(btn_press), 32'h3);
    check("rst_toggle_both", 32'(btn_toggle), 32'h3);
    ticks(2);

    // clean press/release on channel 0
    btn_raw = 2'b00;
    fresh_reset();
    btn_raw[0] = 1'b1;
    wait_pulse(0, 1'b0, lat);
    check("clean_press_lat", lat, 6);
    ticks(14);
    btn_raw[0] = 1'b0;
    wait_pulse(0, 1'b1, lat);
    check("clean_release_lat", lat, 6);
    check("clean_toggle_kept", 32'(btn_toggle[0]), 32'h1);
    ticks(3);

    // bounce rejection on channel 1
    cnt = 0;
    btn_raw[1] = 1'b1; for (int k = 0; k < 3; k++) begin tick(); cnt += btn_press[1]; end
    btn_raw[1] = 1'b0; for (int k = 0; k < 1; k++) begin tick(); cnt += btn_press[1]; end
    btn_raw[1] = 1'b1; for (int k = 0; k < 2; k++) begin tick(); cnt += btn_press[1]; end
    btn_raw[1] = 1'b0; for (int k = 0; k < 2; k++) begin tick(); cnt += btn_press[1]; end
    check("bounce_no_early_press", cnt, 0);
    btn_raw[1] = 1'b1;
    wait_pulse(1, 1'b0, lat);
    check("bounce_press_lat", lat, 6);
    btn_raw[1] = 1'b0;
    ticks(10);

    // toggle sequence over three presses
    fresh_reset();
    for (int p = 0; p < 3; p++) begin
      btn_raw[0] = 1'b1;
      wait_pulse(0, 1'b0, lat);
      tog_seen[0] = btn_toggle[0];
      check($sformatf("toggle_seq%0d", p), 32'(tog_seen[0]), (p % 2 == 0) ? 32'h1 : 32'h0);
      ticks(5);
      btn_raw[0] = 1'b0;
      wait_pulse(0, 1'b1, lat);
      check($sformatf("toggle_hold%0d", p), 32'(btn_toggle[0]), 32'(tog_seen[0]));
      ticks(3);
    end

    // reset during a pending press
    fresh_reset();
    btn_raw[0] = 1'b1;
    ticks(4);
    assert_reset();
    btn_raw[0] = 1'b0;
    ticks(2);
    release_reset();
    cnt = 0;
    for (int k = 0; k < 12; k++) begin tick(); cnt += btn_press[0]; end
    check("midpend_no_press", cnt, 0);
    check("midpend_level", 32'(btn_level), 32'h0);

    // channel independence
    fresh_reset();
    btn_raw[0] = 1'b1;
    lat = -1;
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      btn_raw[1] = (k % 3) != 0;
      tick();
      if (btn_press[0] && lat < 0) lat = k;
      cnt += btn_press[1] + btn_level[1] + btn_release[1];
    end
    check("indep_press_lat", lat, 6);
    check("indep_ch1_quiet", cnt, 0);
    btn_raw = 2'b00;
    ticks(10);

    // randomized phase
    for (int ch = 0; ch < N; ch++) hold[ch] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        tick();
        release_reset();
      end
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          btn_raw[ch] = ~btn_raw[ch];
          hold[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 14)) : int'($urandom_range(1, 4));
        end
        hold[ch]--;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
